// File: rtl/vga_text_console_if.sv
// Byte-stream input and vga character-write port of the text console.
interface vga_text_console_if;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  write_char;
    logic [10:0] write_char_pos;
    logic        write_char_strobe;
    logic [10:0] cursor_pos;

    // Byte producer (CPU bus / UART bridge side)
    modport master (
        output in_data, in_valid,
        input  in_ready, write_char, write_char_pos, write_char_strobe, cursor_pos
    );

    // Console side
    modport slave (
        input  in_data, in_valid,
        output in_ready, write_char, write_char_pos, write_char_strobe, cursor_pos
    );
endinterface

// File: rtl/vga_text_console.sv
// Text console: interprets a byte stream with control codes, tracks a
// row/column cursor and issues single-cycle character writes to the vga core.
module vga_text_console #(
    parameter int unsigned COLS = 80,
    parameter int unsigned ROWS = 25
) (
    input  logic                CLK,
    input  logic                RST_N,
    vga_text_console_if.slave   bus
);

    localparam int unsigned CELLS = COLS * ROWS;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

    state_t      state_q, state_d;
    logic [10:0] row_q, row_d;
    logic [10:0] col_q, col_d;
    logic [10:0] pos_q, pos_d;
    logic [11:0] clr_q, clr_d;
    logic [7:0]  wchar_q, wchar_d;
    logic [10:0] wpos_q, wpos_d;
    logic        wstb_q, wstb_d;

    logic        accept;
    logic        last_row;
    logic [10:0] nl_row;
    logic [10:0] nl_pos;
    logic [11:0] tab_col;

    assign bus.in_ready          = (state_q == IDLE);
    assign bus.write_char        = wchar_q;
    assign bus.write_char_pos    = wpos_q;
    assign bus.write_char_strobe = wstb_q;
    assign bus.cursor_pos        = pos_q;

    assign accept = bus.in_valid && (state_q == IDLE);

    // Cursor targets for a row advance (LF, tab overflow, end of line), with wrap to top
    always_comb begin
        last_row = (row_q == 11'(ROWS - 1));
        nl_row   = last_row ? '0 : row_q + 11'd1;
        nl_pos   = last_row ? '0 : pos_q + (11'(COLS) - col_q);
        tab_col  = ({1'b0, col_q} | 12'd7) + 12'd1;
    end

    // State, cursor and write-port registers
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= IDLE;
            row_q   <= '0;
            col_q   <= '0;
            pos_q   <= '0;
            clr_q   <= '0;
            wchar_q <= '0;
            wpos_q  <= '0;
            wstb_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            col_q   <= col_d;
            pos_q   <= pos_d;
            clr_q   <= clr_d;
            wchar_q <= wchar_d;
            wpos_q  <= wpos_d;
            wstb_q  <= wstb_d;
        end
    end

    // Byte interpretation, clear sweep and next write
    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        col_d   = col_q;
        pos_d   = pos_q;
        clr_d   = clr_q;
        wchar_d = wchar_q;
        wpos_d  = wpos_q;
        wstb_d  = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    case (bus.in_data)
                        8'h0A: begin
                            col_d = '0;
                            row_d = nl_row;
                            pos_d = nl_pos;
                        end
                        8'h0D: begin
                            col_d = '0;
                            pos_d = pos_q - col_q;
                        end
                        8'h09: begin
                            if (tab_col >= 12'(COLS)) begin
                                col_d = '0;
                                row_d = nl_row;
                                pos_d = nl_pos;
                            end else begin
                                col_d = tab_col[10:0];
                                pos_d = pos_q + (tab_col[10:0] - col_q);
                            end
                        end
                        8'h08: begin
                            if (col_q != '0) begin
                                col_d   = col_q - 11'd1;
                                pos_d   = pos_q - 11'd1;
                                wstb_d  = 1'b1;
                                wchar_d = 8'h20;
                                wpos_d  = pos_q - 11'd1;
                            end
                        end
                        8'h0C: begin
                            // Cell 0 is written on the accepting edge so the sweep
                            // starts the very next cycle; clr then holds the next cell.
                            state_d = CLEAR;
                            wstb_d  = 1'b1;
                            wchar_d = 8'h20;
                            wpos_d  = '0;
                            clr_d   = 12'd1;
                        end
                        default: begin
                            wstb_d  = 1'b1;
                            wchar_d = bus.in_data;
                            wpos_d  = pos_q;
                            if (col_q == 11'(COLS - 1)) begin
                                col_d = '0;
                                row_d = nl_row;
                                pos_d = nl_pos;
                            end else begin
                                col_d = col_q + 11'd1;
                                pos_d = pos_q + 11'd1;
                            end
                        end
                    endcase
                end
            end
            CLEAR: begin
                if (clr_q == 12'(CELLS)) begin
                    state_d = IDLE;
                    row_d   = '0;
                    col_d   = '0;
                    pos_d   = '0;
                    clr_d   = '0;
                end else begin
                    wstb_d  = 1'b1;
                    wchar_d = 8'h20;
                    wpos_d  = clr_q[10:0];
                    clr_d   = clr_q + 12'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_vga_text_console.sv
// Directed bench for vga_text_console: vector table plus multi-cycle sequences.
module tb_vga_text_console;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    vga_text_console_if bus ();

    vga_text_console #(
        .COLS(80),
        .ROWS(25)
    ) dut (
        .CLK  (clk),
        .RST_N(rst_n),
        .bus  (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  d;
        bit          stb;
        logic [7:0]  ch;
        logic [10:0] pos;
        logic [10:0] cur;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Present one byte, expect acceptance, and check the cycle after the edge
    task automatic send(input logic [7:0] d, input bit es, input logic [7:0] ec,
                        input logic [10:0] ep, input logic [10:0] cur, input string nm);
        @(negedge clk);
        bus.in_data  = d;
        bus.in_valid = 1'b1;
        chk({nm, " ready"}, 32'(bus.in_ready), 32'd1);
        @(posedge clk);
        #1;
        chk({nm, " strobe"}, 32'(bus.write_char_strobe), 32'(es));
        if (es) begin
            chk({nm, " char"}, 32'(bus.write_char), 32'(ec));
            chk({nm, " pos"}, 32'(bus.write_char_pos), 32'(ep));
        end
        chk({nm, " cursor"}, 32'(bus.cursor_pos), 32'(cur));
    endtask

    task automatic idle();
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    initial begin
        int cnt;
        int k;
        checks       = 0;
        failures     = 0;
        rst_n        = 1'b0;
        bus.in_data  = 8'h00;
        bus.in_valid = 1'b0;

        tbl.push_back('{8'h41, 1'b1, 8'h41, 11'd0,  11'd1});
        tbl.push_back('{8'h42, 1'b1, 8'h42, 11'd1,  11'd2});
        tbl.push_back('{8'h43, 1'b1, 8'h43, 11'd2,  11'd3});
        tbl.push_back('{8'h0D, 1'b0, 8'h00, 11'd0,  11'd0});
        tbl.push_back('{8'h78, 1'b1, 8'h78, 11'd0,  11'd1});
        tbl.push_back('{8'h78, 1'b1, 8'h78, 11'd1,  11'd2});
        tbl.push_back('{8'h78, 1'b1, 8'h78, 11'd2,  11'd3});
        tbl.push_back('{8'h78, 1'b1, 8'h78, 11'd3,  11'd4});
        tbl.push_back('{8'h78, 1'b1, 8'h78, 11'd4,  11'd5});
        tbl.push_back('{8'h0D, 1'b0, 8'h00, 11'd0,  11'd0});
        tbl.push_back('{8'h0A, 1'b0, 8'h00, 11'd0,  11'd80});
        tbl.push_back('{8'h79, 1'b1, 8'h79, 11'd80, 11'd81});
        tbl.push_back('{8'h0D, 1'b0, 8'h00, 11'd0,  11'd80});
        tbl.push_back('{8'h09, 1'b0, 8'h00, 11'd0,  11'd88});
        tbl.push_back('{8'h61, 1'b1, 8'h61, 11'd88, 11'd89});
        tbl.push_back('{8'h09, 1'b0, 8'h00, 11'd0,  11'd96});
        tbl.push_back('{8'h62, 1'b1, 8'h62, 11'd96, 11'd97});
        tbl.push_back('{8'h0A, 1'b0, 8'h00, 11'd0,  11'd160});

        // Reset values
        repeat (2) @(posedge clk);
        #1;
        chk("rst strobe", 32'(bus.write_char_strobe), 32'd0);
        chk("rst char", 32'(bus.write_char), 32'd0);
        chk("rst pos", 32'(bus.write_char_pos), 32'd0);
        chk("rst cursor", 32'(bus.cursor_pos), 32'd0);
        chk("rst ready", 32'(bus.in_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;

        // Table vectors, back-to-back
        foreach (tbl[i])
            send(tbl[i].d, tbl[i].stb, tbl[i].ch, tbl[i].pos, tbl[i].cur, $sformatf("vec%0d", i));

        // Row 2: fill to col 78, TAB there acts as LF
        for (int i = 0; i < 78; i++)
            send(8'h70, 1'b1, 8'h70, 11'(160 + i), 11'(161 + i), "fill78");
        send(8'h09, 1'b0, 8'h00, 11'd0, 11'd240, "tab col78");
        // Row 3: 'b' at col 79 moves the cursor to the next row
        for (int i = 0; i < 79; i++)
            send(8'h70, 1'b1, 8'h70, 11'(240 + i), 11'(241 + i), "fill79");
        send(8'h62, 1'b1, 8'h62, 11'd319, 11'd320, "b col79");

        // Down to row 24, fill to 1999, 'z' wraps to 0
        for (int i = 1; i <= 20; i++)
            send(8'h0A, 1'b0, 8'h00, 11'd0, 11'(320 + 80 * i), "lf down");
        for (int i = 0; i < 79; i++)
            send(8'h70, 1'b1, 8'h70, 11'(1920 + i), 11'(1921 + i), "fill last");
        send(8'h7A, 1'b1, 8'h7A, 11'd1999, 11'd0, "z wrap");
        for (int i = 1; i <= 24; i++)
            send(8'h0A, 1'b0, 8'h00, 11'd0, 11'(80 * i), "lf rows");
        send(8'h0A, 1'b0, 8'h00, 11'd0, 11'd0, "lf wrap");

        // Backspace
        for (int i = 0; i < 10; i++)
            send(8'h6D, 1'b1, 8'h6D, 11'(i), 11'(i + 1), "m fill");
        send(8'h6B, 1'b1, 8'h6B, 11'd10, 11'd11, "k");
        send(8'h08, 1'b1, 8'h20, 11'd10, 11'd10, "bs");
        send(8'h0D, 1'b0, 8'h00, 11'd0, 11'd0, "cr");
        send(8'h08, 1'b0, 8'h00, 11'd0, 11'd0, "bs col0");

        // Form feed with 'q' queued behind it
        @(negedge clk);
        bus.in_data  = 8'h0C;
        bus.in_valid = 1'b1;
        chk("ff ready", 32'(bus.in_ready), 32'd1);
        @(posedge clk);
        #1;
        bus.in_data = 8'h71;
        cnt = 0;
        k   = 0;
        while (k < 2100) begin
            if (bus.write_char_strobe) begin
                chk("clr char", 32'(bus.write_char), 32'h20);
                chk("clr pos", 32'(bus.write_char_pos), 32'(cnt));
                chk("clr ready", 32'(bus.in_ready), 32'd0);
                cnt++;
            end else if (bus.in_ready) begin
                break;
            end
            k++;
            @(posedge clk);
            #1;
        end
        chk("clr count", 32'(cnt), 32'd2000);
        chk("clr cycles", 32'(k), 32'd2000);
        chk("clr cursor", 32'(bus.cursor_pos), 32'd0);
        @(posedge clk);
        #1;
        chk("q strobe", 32'(bus.write_char_strobe), 32'd1);
        chk("q char", 32'(bus.write_char), 32'h71);
        chk("q pos", 32'(bus.write_char_pos), 32'd0);
        chk("q cursor", 32'(bus.cursor_pos), 32'd1);
        idle();

        // Reset asserted in the middle of a clear sweep
        send(8'h0C, 1'b1, 8'h20, 11'd0, 11'd1, "ff2");
        bus.in_valid = 1'b0;
        repeat (500) @(posedge clk);
        #1;
        chk("mid clr strobe", 32'(bus.write_char_strobe), 32'd1);
        chk("mid clr pos", 32'(bus.write_char_pos), 32'd500);
        #2;
        rst_n = 1'b0;
        #1;
        chk("abort strobe", 32'(bus.write_char_strobe), 32'd0);
        chk("abort char", 32'(bus.write_char), 32'd0);
        chk("abort pos", 32'(bus.write_char_pos), 32'd0);
        chk("abort cursor", 32'(bus.cursor_pos), 32'd0);
        chk("abort ready", 32'(bus.in_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        send(8'h72, 1'b1, 8'h72, 11'd0, 11'd1, "after abort");
        idle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
